// File: rtl/simon_iter_ctrl.sv
// Iterative Simon128/128 encryption engine: one round per clock with an on-the-fly
// key schedule, an accept -> run -> deliver sequence, abort, and output backpressure.
module simon_iter_ctrl #(
  parameter int ROUNDS = 68,
  parameter int WORD   = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   pt_i,
  input  logic [127:0]   key_i,
  input  logic           abort,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   ct_o,
  output logic           busy,
  output logic [6:0]     round_o
);

  // Handshakes: a request transfers on an edge where in_valid && in_ready; a result
  // transfers on an edge where out_valid && out_ready (and abort is low). in_valid is
  // ignored while busy, and ct_o is held stable with out_valid until the transfer.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // z2 stored so that its leftmost character is bit 61; sequence index zi maps to 61-zi.
  localparam logic [61:0] Z2       = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [6:0]  LAST_RND = 7'(ROUNDS - 1);
  localparam logic [5:0]  LAST_ZI  = 6'd61;

  state_t            state;
  logic [WORD-1:0]   x;
  logic [WORD-1:0]   y;
  logic [WORD-1:0]   k0;
  logic [WORD-1:0]   k1;
  logic [6:0]        rnd;
  logic [5:0]        zi;

  logic [WORD-1:0]   f_x;
  logic [WORD-1:0]   x_next;
  logic [WORD-1:0]   k1_r3;
  logic [WORD-1:0]   t_key;
  logic [WORD-1:0]   k_new;
  logic              z_bit;
  logic              last_rnd;

  function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] v, input int n);
    return (v << n) | (v >> (WORD - n));
  endfunction

  function automatic logic [WORD-1:0] ror(input logic [WORD-1:0] v, input int n);
    return (v >> n) | (v << (WORD - n));
  endfunction

  always_comb begin
    f_x      = (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    x_next   = y ^ f_x ^ k0;
    k1_r3    = ror(k1, 3);
    t_key    = k1_r3 ^ ror(k1_r3, 1);
    z_bit    = Z2[LAST_ZI - zi];
    k_new    = ~k0 ^ t_key ^ {{(WORD-1){1'b0}}, z_bit} ^ WORD'(3);
    last_rnd = (rnd == LAST_RND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      k0        <= '0;
      k1        <= '0;
      rnd       <= '0;
      zi        <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      round_o   <= '0;
      ct_o      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            x        <= pt_i[127:64];
            y        <= pt_i[63:0];
            k1       <= key_i[127:64];
            k0       <= key_i[63:0];
            rnd      <= '0;
            zi       <= '0;
            state    <= S_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            round_o  <= '0;
          end
        end

        S_RUN: begin
          if (abort) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            round_o  <= '0;
          end else begin
            x   <= x_next;
            y   <= x;
            k0  <= k1;
            k1  <= k_new;
            rnd <= rnd + 7'd1;
            zi  <= (zi == LAST_ZI) ? 6'd0 : zi + 6'd1;
            if (last_rnd) begin
              // The final round's outputs go straight into the held ciphertext register.
              state     <= S_DONE;
              out_valid <= 1'b1;
              ct_o      <= {x_next, x};
              round_o   <= '0;
            end else begin
              round_o <= rnd + 7'd1;
            end
          end
        end

        S_DONE: begin
          if (abort || out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            ct_o      <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          round_o   <= '0;
          ct_o      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_iter_ctrl.sv
// Bench for simon_iter_ctrl: known-answer, backpressure, busy rejection, abort, mid-run
// reset and randomized blocks checked against a plain Simon128/128 reference function.
module tb_simon_iter_ctrl;

  localparam logic [127:0] KAT_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_PT  = 128'h6373656420737265_6c6c657661727420;
  localparam logic [127:0] KAT_CT  = 128'h49681b1e1e54fe3f_65aa832af84e0bbc;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt_i;
  logic [127:0] key_i;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct_o;
  logic         busy;
  logic [6:0]   round_o;

  logic [127:0] exp_q[$];
  int           n_pass;
  int           n_total;
  int           cyc;
  int           accept_cyc;
  bit           started;
  bit           prev_ov;

  simon_iter_ctrl #(.ROUNDS(68), .WORD(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_i      (pt_i),
    .key_i     (key_i),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct_o      (ct_o),
    .busy      (busy),
    .round_o   (round_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rol64(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [127:0] simon_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [63:0] k[0:67];
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] tmp;
    logic [61:0] z;
    z    = 62'b10101111011100000011010010011000101000010001111110010110110011;
    k[0] = key[63:0];
    k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      tmp      = ror64(k[i+1], 3);
      tmp      = tmp ^ ror64(tmp, 1);
      k[i+2]   = ~k[i] ^ tmp ^ 64'(z[61 - (i % 62)]) ^ 64'd3;
    end
    x = pt[127:64];
    y = pt[63:0];
    for (int i = 0; i < 68; i++) begin
      tmp = x;
      x   = y ^ ((rol64(x, 1) & rol64(x, 8)) ^ rol64(x, 2)) ^ k[i];
      y   = tmp;
    end
    return {x, y};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic fail_note(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (started && !rst) begin
      if (in_valid && in_ready) accept_cyc = cyc + 1;
      if (out_valid && !prev_ov)
        check("latency", 128'(cyc - accept_cyc), 128'd68);
      if (!out_valid && ct_o !== 128'd0)
        check("ct_zero_when_idle", ct_o, 128'd0);
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) fail_note("unexpected_output");
        else check("ciphertext", ct_o, exp_q.pop_front());
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  128'(in_ready),  128'd1);
    check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
    check({tag, "_busy"},      128'(busy),      128'd0);
    check({tag, "_ct_o"},      ct_o,            128'd0);
    check({tag, "_round_o"},   128'(round_o),   128'd0);
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] expct);
    int n;
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    if (!in_ready) fail_note("send_wait_ready");
    in_valid = 1'b1;
    pt_i     = pt;
    key_i    = key;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(expct);
  endtask

  task automatic wait_round(input logic [6:0] r);
    int n;
    n = 0;
    while (round_o !== r && n < 200) begin
      tick();
      n++;
    end
    if (round_o !== r) fail_note("wait_round");
  endtask

  task automatic drain(input bit rand_rdy);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && in_ready) && n < 600) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (!(exp_q.size() == 0 && in_ready)) fail_note("drain");
    out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] rpt;
    logic [127:0] rkey;
    int n;
    n_pass = 0; n_total = 0; cyc = 0; accept_cyc = 0;
    started = 1'b0; prev_ov = 1'b0;
    rst = 1'b1; in_valid = 1'b0; pt_i = '0; key_i = '0; abort = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    started = 1'b1;
    check_reset_values("reset");

    // Known-answer vector with the consumer always ready.
    send(KAT_PT, KAT_KEY, KAT_CT);
    drain(1'b0);

    // Backpressure: hold the result for 10 cycles, then deliver.
    out_ready = 1'b0;
    send(KAT_PT, KAT_KEY, KAT_CT);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) fail_note("bp_wait_valid");
    for (int i = 0; i < 10; i++) begin
      check("bp_ct_held",     ct_o,             KAT_CT);
      check("bp_valid_held",  128'(out_valid),  128'd1);
      check("bp_in_ready_lo", 128'(in_ready),   128'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after", 128'(in_ready),  128'd1);
    check("bp_valid_after",    128'(out_valid), 128'd0);

    // Busy rejection: a second request mid-run is ignored.
    send(KAT_PT, KAT_KEY, KAT_CT);
    wait_round(7'd20);
    in_valid = 1'b1;
    pt_i     = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    check("busy_in_ready", 128'(in_ready), 128'd0);
    check("busy_busy",     128'(busy),     128'd1);
    tick();
    in_valid = 1'b0;
    drain(1'b0);

    // Abort at round 30: back to idle, block discarded.
    send(KAT_PT, KAT_KEY, KAT_CT);
    wait_round(7'd30);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    void'(exp_q.pop_back());
    check_reset_values("abort");
    repeat (80) begin
      if (out_valid) check("abort_no_valid", 128'(out_valid), 128'd0);
      tick();
    end
    send(KAT_PT, KAT_KEY, KAT_CT);
    drain(1'b0);

    // Mid-run reset at round 50.
    send(KAT_PT, KAT_KEY, KAT_CT);
    wait_round(7'd50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_reset_values("midrst");
    send(KAT_PT, KAT_KEY, KAT_CT);
    drain(1'b0);

    // Randomized blocks with random consumer backpressure.
    for (int b = 0; b < 8; b++) begin
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      rkey = {$urandom, $urandom, $urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      send(rpt, rkey, simon_ref(rpt, rkey));
      drain(1'b1);
    end

    // Reference model against the published vector.
    check("model_kat", simon_ref(KAT_PT, KAT_KEY), KAT_CT);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
